radar_frame_parser: RTL and testbench

Receive-side parser for the framed 64-bit ADC capture stream produced by the radar sample synchronizer. It sits downstream of the ADC AXI-stream FIFO. It strips the FRST and LAST marker words, captures their 32-bit timestamps, and forwards the payload words with tlast regenerated on the final payload word. It also reports per-frame length and protocol errors to the control/status registers.

---
 rtl/radar_frame_pkg.sv | 30 +++
 rtl/radar_frame_outreg.sv | 41 ++++
 rtl/radar_frame_parser.sv | 152 +++++++++++++++
 tb/tb_radar_frame_parser.sv | 326 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/radar_frame_pkg.sv
// rtl/radar_frame_pkg.sv - marker constants, state and word-kind types shared by the frame parser
package radar_frame_pkg;

  // Marker values are also used by the sample synchronizer that builds the frames
  localparam logic [31:0] FIRST_CMD_DEFAULT = 32'h4652_5354;
  localparam logic [31:0] LAST_CMD_DEFAULT  = 32'h4c41_5354;

  typedef enum logic {
    HUNT  = 1'b0,
    FRAME = 1'b1
  } state_t;

  typedef enum logic [1:0] {
    WORD_DATA  = 2'd0,
    WORD_FIRST = 2'd1,
    WORD_LAST  = 2'd2
  } word_kind_t;

  function automatic word_kind_t classify_word(input logic [31:0] low_half,
                                               input logic [31:0] first_cmd,
                                               input logic [31:0] last_cmd);
    if (low_half == first_cmd) begin
      return WORD_FIRST;
    end else if (low_half == last_cmd) begin
      return WORD_LAST;
    end
    return WORD_DATA;
  endfunction

endpackage

// File: rtl/radar_frame_outreg.sv
// rtl/radar_frame_outreg.sv - single-entry payload output register with valid/ready
module radar_frame_outreg (
  input  logic        clk,
  input  logic        reset,
  input  logic        load,
  input  logic [63:0] load_data,
  input  logic        load_last,
  input  logic        m_tready,
  output logic        o_valid,
  output logic [63:0] o_data,
  output logic        o_last
);

  logic        valid_q, valid_d;
  logic [63:0] data_q, data_d;
  logic        last_q, last_d;

  // The parent only asserts load when the register is empty or draining this cycle
  always_comb begin
    valid_d = load | (valid_q & ~m_tready);
    data_d  = load ? load_data : data_q;
    last_d  = load ? load_last : last_q;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      valid_q <= 1'b0;
      data_q  <= 64'd0;
      last_q  <= 1'b0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
      last_q  <= last_d;
    end
  end

  assign o_valid = valid_q;
  assign o_data  = data_q;
  assign o_last  = last_q;

endmodule

// File: rtl/radar_frame_parser.sv
// rtl/radar_frame_parser.sv - strips FRST/LAST markers, forwards payload with regenerated tlast
module radar_frame_parser
  import radar_frame_pkg::*;
#(
  parameter int unsigned ALIGN_WORDS = 0,
  parameter logic [31:0] FIRST_CMD   = FIRST_CMD_DEFAULT,
  parameter logic [31:0] LAST_CMD    = LAST_CMD_DEFAULT
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [63:0] s_axis_tdata,
  input  logic        s_axis_tvalid,
  output logic        s_axis_tready,
  output logic [63:0] m_axis_tdata,
  output logic        m_axis_tvalid,
  output logic        m_axis_tlast,
  input  logic        m_axis_tready,
  output logic [31:0] frame_start_ts,
  output logic [31:0] frame_end_ts,
  output logic [31:0] frame_len,
  output logic        frame_done,
  output logic        err_truncated,
  output logic        err_misaligned,
  output logic [15:0] dropped_words
);

  localparam logic [31:0] ALIGN_MASK = (ALIGN_WORDS == 0) ? 32'd0 : 32'(ALIGN_WORDS - 1);

  state_t      state_q, state_d;
  logic        h_valid_q, h_valid_d;
  logic [63:0] h_data_q, h_data_d;
  logic [31:0] count_q, count_d;
  logic [31:0] start_ts_q, start_ts_d;
  logic [31:0] end_ts_q, end_ts_d;
  logic [31:0] len_q, len_d;
  logic        done_q, done_d;
  logic        trunc_q, trunc_d;
  logic        misal_q, misal_d;
  logic [15:0] dropped_q, dropped_d;

  logic        o_valid;
  logic        o_load;
  logic        o_last_in;
  logic        accept;
  word_kind_t  kind;

  assign kind          = classify_word(s_axis_tdata[31:0], FIRST_CMD, LAST_CMD);
  assign s_axis_tready = (state_q == HUNT) | ~o_valid | m_axis_tready;
  assign accept        = s_axis_tvalid & s_axis_tready;

  always_comb begin
    state_d    = state_q;
    h_valid_d  = h_valid_q;
    h_data_d   = h_data_q;
    count_d    = count_q;
    start_ts_d = start_ts_q;
    end_ts_d   = end_ts_q;
    len_d      = len_q;
    dropped_d  = dropped_q;
    done_d     = 1'b0;
    trunc_d    = 1'b0;
    misal_d    = 1'b0;
    o_load     = 1'b0;
    o_last_in  = 1'b0;

    if (accept) begin
      if (state_q == HUNT) begin
        if (kind == WORD_FIRST) begin
          start_ts_d = s_axis_tdata[63:32];
          count_d    = 32'd0;
          state_d    = FRAME;
        end else if (dropped_q != 16'hFFFF) begin
          dropped_d = dropped_q + 16'd1;
        end
      end else if (kind == WORD_DATA) begin
        // One word of lookahead in H lets tlast land on the real final payload word
        o_load    = h_valid_q;
        h_valid_d = 1'b1;
        h_data_d  = s_axis_tdata;
        if (count_q != 32'hFFFF_FFFF) begin
          count_d = count_q + 32'd1;
        end
      end else begin
        o_load    = h_valid_q;
        o_last_in = 1'b1;
        h_valid_d = 1'b0;
        len_d     = count_q;
        done_d    = 1'b1;
        misal_d   = |(count_q & ALIGN_MASK);
        if (kind == WORD_LAST) begin
          end_ts_d = s_axis_tdata[63:32];
          state_d  = HUNT;
        end else begin
          // FRST inside a frame closes the old frame and opens a new one
          trunc_d    = 1'b1;
          start_ts_d = s_axis_tdata[63:32];
          count_d    = 32'd0;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= HUNT;
      h_valid_q  <= 1'b0;
      h_data_q   <= 64'd0;
      count_q    <= 32'd0;
      start_ts_q <= 32'd0;
      end_ts_q   <= 32'd0;
      len_q      <= 32'd0;
      done_q     <= 1'b0;
      trunc_q    <= 1'b0;
      misal_q    <= 1'b0;
      dropped_q  <= 16'd0;
    end else begin
      state_q    <= state_d;
      h_valid_q  <= h_valid_d;
      h_data_q   <= h_data_d;
      count_q    <= count_d;
      start_ts_q <= start_ts_d;
      end_ts_q   <= end_ts_d;
      len_q      <= len_d;
      done_q     <= done_d;
      trunc_q    <= trunc_d;
      misal_q    <= misal_d;
      dropped_q  <= dropped_d;
    end
  end

  radar_frame_outreg u_outreg (
    .clk       (clk),
    .reset     (reset),
    .load      (o_load),
    .load_data (h_data_q),
    .load_last (o_last_in),
    .m_tready  (m_axis_tready),
    .o_valid   (o_valid),
    .o_data    (m_axis_tdata),
    .o_last    (m_axis_tlast)
  );

  assign m_axis_tvalid  = o_valid;
  assign frame_start_ts = start_ts_q;
  assign frame_end_ts   = end_ts_q;
  assign frame_len      = len_q;
  assign frame_done     = done_q;
  assign err_truncated  = trunc_q;
  assign err_misaligned = misal_q;
  assign dropped_words  = dropped_q;

endmodule

// File: tb/tb_radar_frame_parser.sv
// tb/tb_radar_frame_parser.sv - scoreboard bench for radar_frame_parser (ALIGN_WORDS=4)
module tb_radar_frame_parser;

  logic        clk = 1'b0;
  logic        reset;
  logic [63:0] s_axis_tdata;
  logic        s_axis_tvalid;
  logic        s_axis_tready;
  logic [63:0] m_axis_tdata;
  logic        m_axis_tvalid;
  logic        m_axis_tlast;
  logic        m_axis_tready;
  logic [31:0] frame_start_ts;
  logic [31:0] frame_end_ts;
  logic [31:0] frame_len;
  logic        frame_done;
  logic        err_truncated;
  logic        err_misaligned;
  logic [15:0] dropped_words;

  typedef struct {
    logic [63:0] d;
    logic        l;
  } beat_t;

  typedef struct {
    logic [31:0] len;
    logic [31:0] sts;
    logic [31:0] ets;
    logic        trunc;
    logic        mis;
  } stat_t;

  beat_t exp_beats[$];
  stat_t exp_stats[$];

  int   vectors = 0;
  int   errors  = 0;
  logic bp_en   = 1'b0;
  logic rdy_fixed = 1'b1;

  logic        stall_pend = 1'b0;
  logic [63:0] stall_d;
  logic        stall_l;

  always #5 clk = ~clk;

  radar_frame_parser #(.ALIGN_WORDS(4)) dut (
    .clk            (clk),
    .reset          (reset),
    .s_axis_tdata   (s_axis_tdata),
    .s_axis_tvalid  (s_axis_tvalid),
    .s_axis_tready  (s_axis_tready),
    .m_axis_tdata   (m_axis_tdata),
    .m_axis_tvalid  (m_axis_tvalid),
    .m_axis_tlast   (m_axis_tlast),
    .m_axis_tready  (m_axis_tready),
    .frame_start_ts (frame_start_ts),
    .frame_end_ts   (frame_end_ts),
    .frame_len      (frame_len),
    .frame_done     (frame_done),
    .err_truncated  (err_truncated),
    .err_misaligned (err_misaligned),
    .dropped_words  (dropped_words)
  );

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  function automatic logic [63:0] dw(input int n);
    return {32'hDA7A_0000 + 32'(n), 32'h0000_1000 + 32'(n)};
  endfunction

  task automatic send(input logic [63:0] w);
    int t;
    s_axis_tdata  = w;
    s_axis_tvalid = 1'b1;
    t = 0;
    @(negedge clk);
    while (!s_axis_tready && t < 1000) begin
      @(negedge clk);
      t++;
    end
    if (t >= 1000) begin
      vectors++;
      errors++;
      $display("FAIL send_timeout: got tready=0 expected 1 within 1000 cycles");
    end
    @(posedge clk);
    #1;
  endtask

  task automatic frst(input logic [31:0] ts);
    send({ts, 32'h4652_5354});
  endtask

  task automatic lst(input logic [31:0] ts);
    send({ts, 32'h4c41_5354});
  endtask

  task automatic idle();
    s_axis_tvalid = 1'b0;
  endtask

  task automatic exp_b(input logic [63:0] d, input logic l);
    beat_t b;
    b.d = d;
    b.l = l;
    exp_beats.push_back(b);
  endtask

  task automatic exp_s(input logic [31:0] len, input logic [31:0] sts, input logic [31:0] ets,
                       input logic trunc, input logic mis);
    stat_t s;
    s.len = len; s.sts = sts; s.ets = ets; s.trunc = trunc; s.mis = mis;
    exp_stats.push_back(s);
  endtask

  task automatic drain();
    int t;
    t = 0;
    while ((exp_beats.size() != 0 || exp_stats.size() != 0) && t < 5000) begin
      @(negedge clk);
      t++;
    end
    repeat (4) @(negedge clk);
    chk("beats_outstanding", 64'(exp_beats.size()), 64'd0);
    chk("frames_outstanding", 64'(exp_stats.size()), 64'd0);
    exp_beats.delete();
    exp_stats.delete();
    @(posedge clk);
    #1;
  endtask

  // m_axis_tready driver: fixed level or random backpressure
  initial begin
    m_axis_tready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      m_axis_tready = bp_en ? 1'($urandom_range(0, 1)) : rdy_fixed;
    end
  end

  // Monitor: pops expected beats/frames whenever the DUT presents them
  always @(negedge clk) begin
    if (reset) begin
      stall_pend = 1'b0;
    end else begin
      if (stall_pend) begin
        chk("stall_tvalid", 64'(m_axis_tvalid), 64'd1);
        chk("stall_tdata", m_axis_tdata, stall_d);
        chk("stall_tlast", 64'(m_axis_tlast), 64'(stall_l));
      end
      if (m_axis_tvalid && m_axis_tready) begin
        if (exp_beats.size() == 0) begin
          vectors++;
          errors++;
          $display("FAIL beat_unexpected: got %h expected no beat", m_axis_tdata);
        end else begin
          beat_t b;
          b = exp_beats.pop_front();
          chk("beat_tdata", m_axis_tdata, b.d);
          chk("beat_tlast", 64'(m_axis_tlast), 64'(b.l));
        end
      end
      stall_pend = m_axis_tvalid && !m_axis_tready;
      stall_d    = m_axis_tdata;
      stall_l    = m_axis_tlast;
      if (frame_done) begin
        if (exp_stats.size() == 0) begin
          vectors++;
          errors++;
          $display("FAIL frame_unexpected: got frame_done len=%0d expected none", frame_len);
        end else begin
          stat_t s;
          s = exp_stats.pop_front();
          chk("frame_len", 64'(frame_len), 64'(s.len));
          chk("frame_start_ts", 64'(frame_start_ts), 64'(s.sts));
          chk("frame_end_ts", 64'(frame_end_ts), 64'(s.ets));
          chk("err_truncated", 64'(err_truncated), 64'(s.trunc));
          chk("err_misaligned", 64'(err_misaligned), 64'(s.mis));
        end
      end else if (err_truncated || err_misaligned) begin
        vectors++;
        errors++;
        $display("FAIL err_without_done: got trunc=%b mis=%b expected 0", err_truncated, err_misaligned);
      end
    end
  end

  initial begin
    reset = 1'b1;
    s_axis_tvalid = 1'b0;
    s_axis_tdata  = 64'd0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_m_tvalid", 64'(m_axis_tvalid), 64'd0);
    chk("rst_m_tlast", 64'(m_axis_tlast), 64'd0);
    chk("rst_m_tdata", m_axis_tdata, 64'd0);
    chk("rst_s_tready", 64'(s_axis_tready), 64'd1);
    chk("rst_frame_len", 64'(frame_len), 64'd0);
    chk("rst_start_ts", 64'(frame_start_ts), 64'd0);
    chk("rst_end_ts", 64'(frame_end_ts), 64'd0);
    chk("rst_frame_done", 64'(frame_done), 64'd0);
    chk("rst_dropped", 64'(dropped_words), 64'd0);
    @(posedge clk);
    #1;
    reset = 1'b0;

    // Basic 4-word frame
    exp_s(32'd4, 32'h100, 32'h200, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) exp_b(dw(i), i == 3);
    frst(32'h100);
    for (int i = 0; i < 4; i++) send(dw(i));
    lst(32'h200);
    idle();
    drain();

    // Junk while hunting, then a one-word frame
    exp_s(32'd1, 32'h110, 32'h210, 1'b0, 1'b1);
    exp_b(dw(10), 1'b1);
    for (int i = 0; i < 3; i++) send(dw(90 + i));
    frst(32'h110);
    send(dw(10));
    lst(32'h210);
    idle();
    drain();
    chk("dropped_words", 64'(dropped_words), 64'd3);

    // Empty frame
    exp_s(32'd0, 32'h120, 32'h220, 1'b0, 1'b0);
    frst(32'h120);
    lst(32'h220);
    idle();
    drain();

    // Truncation by a second FRST
    exp_s(32'd2, 32'h300, 32'h220, 1'b1, 1'b1);
    exp_s(32'd1, 32'h300, 32'h400, 1'b0, 1'b1);
    exp_b(dw(20), 1'b0);
    exp_b(dw(21), 1'b1);
    exp_b(dw(22), 1'b1);
    frst(32'h250);
    send(dw(20));
    send(dw(21));
    frst(32'h300);
    send(dw(22));
    lst(32'h400);
    idle();
    drain();

    // Alignment: 6 words misaligned, 8 words aligned, back to back
    exp_s(32'd6, 32'h130, 32'h230, 1'b0, 1'b1);
    exp_s(32'd8, 32'h140, 32'h240, 1'b0, 1'b0);
    for (int i = 0; i < 6; i++) exp_b(dw(30 + i), i == 5);
    for (int i = 0; i < 8; i++) exp_b(dw(40 + i), i == 7);
    frst(32'h130);
    for (int i = 0; i < 6; i++) send(dw(30 + i));
    lst(32'h230);
    frst(32'h140);
    for (int i = 0; i < 8; i++) send(dw(40 + i));
    lst(32'h240);
    idle();
    drain();

    // 64-word frame under random backpressure
    bp_en = 1'b1;
    exp_s(32'd64, 32'h150, 32'h250, 1'b0, 1'b0);
    for (int i = 0; i < 64; i++) exp_b(dw(100 + i), i == 63);
    frst(32'h150);
    for (int i = 0; i < 64; i++) send(dw(100 + i));
    lst(32'h250);
    idle();
    drain();
    bp_en = 1'b0;

    // Reset mid-frame with O full and stalled
    rdy_fixed = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    frst(32'h500);
    send(dw(50));
    send(dw(51));
    idle();
    @(negedge clk);
    chk("midframe_tvalid", 64'(m_axis_tvalid), 64'd1);
    chk("midframe_s_tready", 64'(s_axis_tready), 64'd0);
    @(posedge clk);
    #1;
    reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("postrst_tvalid", 64'(m_axis_tvalid), 64'd0);
    chk("postrst_s_tready", 64'(s_axis_tready), 64'd1);
    chk("postrst_frame_len", 64'(frame_len), 64'd0);
    chk("postrst_dropped", 64'(dropped_words), 64'd0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    rdy_fixed = 1'b1;
    repeat (2) @(posedge clk);
    #1;

    // Clean frame after reset
    exp_s(32'd2, 32'h160, 32'h260, 1'b0, 1'b1);
    exp_b(dw(60), 1'b0);
    exp_b(dw(61), 1'b1);
    frst(32'h160);
    send(dw(60));
    send(dw(61));
    lst(32'h260);
    idle();
    drain();
    chk("final_dropped", 64'(dropped_words), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
